// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the size/address to byte-lane mask helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane placement; illegal sizes select no lanes.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: byte_mask = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: byte_mask = 4'b1111;
            default:    byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised data array: one byte-masked write port and one registered read port,
// both on the same clock edge (the read returns the word as it was before that edge's write).
module ahb_sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage and its read register carry no reset so they map onto SRAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: byte/half/word accesses, configurable OKAY wait states,
// two-cycle ERROR response, and write-to-read forwarding for pipelined back-to-back access.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         IW        = ADDR_WIDTH - 2;
    localparam int         DEPTH     = 2 ** IW;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      dp_mask_q;
    logic [IW-1:0]   dp_index_q;
    logic            dp_write_q;
    logic [3:0]      fwd_mask_q;
    logic [31:0]     fwd_data_q;

    logic            accept, illegal, complete, open_addr, take, commit, read_take, fwd_hit;
    logic [3:0]      ap_mask;
    logic [IW-1:0]   ap_index;
    logic [31:0]     sram_rdata, read_word;
    logic            unused_sideband;

    assign unused_sideband = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign ap_mask  = byte_mask(HSIZE, HADDR[1:0]);
    assign ap_index = HADDR[ADDR_WIDTH-1:2];
    assign illegal  = (HSIZE > HSIZE_WORD)
                    | ((HSIZE == HSIZE_HALF) & HADDR[0])
                    | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                    | (HADDR[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]);

    // A new address phase is only evaluated when the previous transfer is finishing.
    assign complete  = (state_q == ST_DATA) && (cnt_q == 4'd0);
    assign open_addr = (state_q == ST_IDLE) || (state_q == ST_ERR2) || complete;
    assign take      = accept & open_addr;
    assign commit    = complete & dp_write_q;
    assign read_take = take & ~illegal & ~HWRITE;
    assign fwd_hit   = commit & read_take & (ap_index == dp_index_q);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_DATA: begin
                HREADYOUT = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
        if (open_addr) begin
            if (take) begin
                state_d = illegal ? ST_ERR1 : ST_DATA;
                cnt_d   = illegal ? 4'd0 : WAIT_INIT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // An errored write is captured as a non-write, so it can never reach the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dp_mask_q  <= 4'b0000;
            dp_index_q <= '0;
            dp_write_q <= 1'b0;
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else if (take) begin
            dp_mask_q  <= ap_mask;
            dp_index_q <= ap_index;
            dp_write_q <= HWRITE & ~illegal;
            fwd_mask_q <= fwd_hit ? dp_mask_q : 4'b0000;
            fwd_data_q <= HWDATA;
        end
    end

    ahb_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk   (CLK),
        .we    (commit),
        .waddr (dp_index_q),
        .be    (dp_mask_q),
        .wdata (HWDATA),
        .re    (read_take),
        .raddr (ap_index),
        .rdata (sram_rdata)
    );

    always_comb begin
        read_word = sram_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_mask_q[b]) read_word[8*b +: 8] = fwd_data_q[8*b +: 8];
        end
    end

    assign HRDATA = (complete & ~dp_write_q) ? read_word : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three responders (0, 2 and 3 wait states) behind a small AHB decoder/mux, driven by a
// pipelined master; a byte-level memory model feeds a scoreboard checked by a bus monitor.
module tb_ahb_sram_slave;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] data;
        logic [3:0]  waits;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  sel, s_ready, s_resp;
    logic [31:0] s_rdata [3];
    logic [1:0]  dsel;
    logic        bus_ready, bus_resp;
    logic [31:0] bus_rdata;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [7:0] ref_mem [3][4096];

    always #5 CLK = ~CLK;

    for (genvar k = 0; k < 3; k++) begin : g_slv
        localparam int WS = (k == 0) ? 0 : (k == 1) ? 2 : 3;
        assign sel[k] = (haddr[31:16] == 16'(k));
        ahb_sram_slave #(
            .ADDR_WIDTH  (12),
            .WAIT_STATES (WS),
            .BASE_ADDR   (32'(k) << 16)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .HSEL      (sel[k]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HMASTLOCK (1'b0),
            .HWDATA    (hwdata),
            .HREADY    (bus_ready),
            .HREADYOUT (s_ready[k]),
            .HRESP     (s_resp[k]),
            .HRDATA    (s_rdata[k])
        );
    end

    // Data-phase slave select; 3 means no slave owns the data phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) dsel <= 2'd3;
        else if (bus_ready) dsel <= (htrans[1] && haddr[31:16] < 16'd3) ? haddr[17:16] : 2'd3;
    end

    always_comb begin
        bus_ready = 1'b1;
        bus_resp  = 1'b0;
        bus_rdata = 32'h0;
        if (dsel != 2'd3) begin
            bus_ready = s_ready[dsel];
            bus_resp  = s_resp[dsel];
            bus_rdata = s_rdata[dsel];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    // Reference: byte-addressed memory per slave; writes land in program order.
    function automatic exp_t model(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                   input logic [31:0] wd);
        exp_t e;
        int   s, off, nbytes, wbase;
        s      = int'(a[31:16]);
        off    = int'(a[15:0]);
        e.err  = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)
                 || (off >= 4096);
        e.rd   = !w;
        e.data = 32'h0;
        e.waits = e.err ? 4'd1 : 4'(ws_of(s));
        if (!e.err) begin
            nbytes = 1 << sz;
            wbase  = off & ~3;
            if (w) begin
                for (int i = 0; i < nbytes; i++) ref_mem[s][off + i] = wd[8*((off + i) % 4) +: 8];
            end else begin
                for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_mem[s][wbase + i];
            end
        end
        return e;
    endfunction

    // Present one address phase, hold it until accepted, then drive its write data.
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd);
        bit ok;
        ok     = 1'b0;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            if (bus_ready) begin
                @(posedge CLK);
                ok = 1'b1;
            end
        end
        if (!ok) check("accept_in_budget", 32'(ok), 32'd1);
        else exp_q.push_back(model(a, w, sz, wd));
        #1;
        hwdata = wd;
        htrans = 2'b00;
    endtask

    task automatic drain();
        htrans = 2'b00;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) check("drain_in_budget", 32'(exp_q.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin : monitor
        bit   in_dp, low_bad;
        int   waits;
        exp_t e;
        in_dp   = 1'b0;
        low_bad = 1'b0;
        waits   = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                in_dp   = 1'b0;
                low_bad = 1'b0;
                waits   = 0;
                exp_q.delete();
                continue;
            end
            if (in_dp) begin
                if (!bus_ready) begin
                    waits++;
                    if (exp_q.size() != 0 && bus_resp !== exp_q[0].err) low_bad = 1'b1;
                end else begin
                    check("expected_entry_present", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("hresp", 32'(bus_resp), 32'(e.err));
                        check("wait_cycles", 32'(waits), 32'(e.waits));
                        check("resp_during_waits", 32'(low_bad), 32'd0);
                        check("hrdata", bus_rdata, (e.rd && !e.err) ? e.data : 32'h0);
                    end
                    waits   = 0;
                    low_bad = 1'b0;
                    in_dp   = 1'b0;
                end
            end
            if (bus_ready) in_dp = htrans[1] && (haddr[31:16] < 16'd3);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [2:0]  sz;
        int          s;
        RST    = 1'b1;
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd2;
        hwdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_hreadyout", 32'(s_ready[k]), 32'd1);
            check("reset_hresp", 32'(s_resp[k]), 32'd0);
            check("reset_hrdata", s_rdata[k], 32'h0);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Word write/read, then byte and half merges over the same word.
        issue(32'h0000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF);
        drain();
        issue(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        drain();
        issue(32'h0000_0013, 1'b1, 3'd0, 32'hAB00_0000);
        issue(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        issue(32'h0000_0012, 1'b1, 3'd1, 32'h1234_0000);
        issue(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        drain();

        // Pipelined write then read of the same word relies on forwarding.
        issue(32'h0000_0020, 1'b1, 3'd2, 32'h1122_3344);
        issue(32'h0000_0020, 1'b0, 3'd2, 32'h0);
        drain();

        // Wait-state slave: held NONSEQ during waits, plus forwarding across waits.
        issue(32'h0001_0010, 1'b1, 3'd2, 32'hA5A5_5A5A);
        issue(32'h0001_0010, 1'b0, 3'd2, 32'h0);
        issue(32'h0001_0011, 1'b0, 3'd0, 32'h0);
        drain();

        // Error responses; the errored write must leave word 0x10 untouched.
        issue(32'h0000_0002, 1'b0, 3'd2, 32'h0);
        issue(32'h0000_0010, 1'b0, 3'd3, 32'h0);
        issue(32'h0000_1000, 1'b0, 3'd2, 32'h0);
        issue(32'h0000_0010, 1'b1, 3'd3, 32'hFFFF_FFFF);
        issue(32'h0000_0011, 1'b1, 3'd1, 32'hFFFF_FFFF);
        issue(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        drain();

        // Prefill a small window of every slave, then randomised traffic.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) issue((32'(k) << 16) | 32'(w * 4), 1'b1, 3'd2, $urandom());
        end
        drain();
        for (int n = 0; n < 300; n++) begin
            s  = $urandom_range(0, 2);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = (32'(s) << 16) | 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | 32'h0000_1000;
            issue(a, 1'($urandom_range(0, 1)), sz, $urandom());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge CLK);
                #1;
            end
        end
        drain();

        // Reset in the middle of a waiting write on the 3-wait-state slave.
        issue(32'h0002_0040, 1'b1, 3'd2, 32'h5555_AAAA);
        drain();
        haddr  = 32'h0002_0040;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        hwdata = 32'hCAFE_F00D;
        htrans = 2'b00;
        @(posedge CLK);
        #1;
        check("ws3_waiting_before_reset", 32'(s_ready[2]), 32'd0);
        RST = 1'b1;
        #1;
        check("abort_hreadyout", 32'(s_ready[2]), 32'd1);
        check("abort_hresp", 32'(s_resp[2]), 32'd0);
        check("abort_hrdata", s_rdata[2], 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        issue(32'h0002_0040, 1'b0, 3'd2, 32'h0);
        issue(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
